uart_rx_loader: RTL

Byte-stream command decoder and program loader that sits directly downstream of the UART receiver (instantiated with 8 data bits). It consumes each received byte and decodes single-byte commands. For a load command it assembles little-endian 32-bit words and writes them sequentially into instruction memory. It also issues one-cycle start/halt pulses to the CPU, so the MIPS core can be programmed and launched over the serial link.

---
 rtl/uart_loader_pkg.sv | 23 ++
 rtl/rx_word_assembler.sv | 34 +++
 rtl/uart_rx_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - command bytes, FSM encoding and sizing helper for the UART program loader
package uart_loader_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LEN_LO = 4'b0010,
        ST_LEN_HI = 4'b0100,
        ST_DATA   = 4'b1000
    } state_t;

    // Bits needed to count 0 .. value-1, never less than one.
    function automatic int clog2(input int value);
        int n;
        n = 1;
        while ((64'd1 << n) < 64'(value)) n++;
        return n;
    endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// rtl/rx_word_assembler.sv - little-endian byte-to-word shift register with byte index and word-ready strobe
module rx_word_assembler #(
    parameter int NB_BYTE = 8
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_valid,
    input  logic [NB_BYTE-1:0]     i_byte,
    output logic [4*NB_BYTE-1:0]   o_word,
    output logic                   o_word_ready
);

    logic [4*NB_BYTE-1:0] r_word;
    logic [1:0]           r_idx;

    // Word including the byte being accepted now, so the 4th byte completes it without a cycle of delay.
    assign o_word       = {i_byte, r_word[4*NB_BYTE-1:NB_BYTE]};
    assign o_word_ready = i_valid & (r_idx == 2'd3);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_idx  <= 2'd0;
        end else if (i_clear) begin
            r_word <= '0;
            r_idx  <= 2'd0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_idx  <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - UART byte-stream command decoder and instruction memory loader
module uart_rx_loader
    import uart_loader_pkg::*;
#(
    parameter int NB_BYTE        = 8,
    parameter int NB_WORD        = 32,
    parameter int NB_ADDR        = 10,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_WORD-1:0] o_imem_wdata,
    output logic               o_cpu_start,
    output logic               o_cpu_halt,
    output logic               o_load_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam int                NB_TMO    = clog2(TIMEOUT_CYCLES);
    localparam logic [NB_TMO-1:0] TMO_LAST  = NB_TMO'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_TMO-1:0] TMO_ONE   = NB_TMO'(1);
    localparam logic [NB_ADDR:0]  WIDX_ONE  = (NB_ADDR + 1)'(1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** NB_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_done_q;
    logic                w_event;
    logic [15:0]         r_count;
    logic [15:0]         w_len;
    logic [NB_ADDR:0]    r_widx;
    logic [NB_TMO-1:0]   r_tmo;
    logic                w_last;
    logic                w_start;
    logic                w_halt;
    logic                w_err;
    logic                w_done;
    logic                w_we;
    logic                w_len_lo_ld;
    logic                w_len_hi_ld;
    logic                w_widx_clr;
    logic                w_asm_valid;
    logic                w_asm_clear;
    logic                w_word_ready;
    logic [NB_WORD-1:0]  w_word;

    assign w_event     = i_rx_done & ~r_done_q;
    assign w_len       = {i_rx_data[7:0], r_count[7:0]};
    assign w_last      = (16'(r_widx) == (r_count - 16'd1));
    assign w_asm_valid = w_event & (r_state == ST_DATA);
    // Held clear outside DATA, so any abort discards a partial word.
    assign w_asm_clear = (r_state != ST_DATA);

    rx_word_assembler #(
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_asm_clear),
        .i_valid      (w_asm_valid),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_halt      = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_we        = 1'b0;
        w_len_lo_ld = 1'b0;
        w_len_hi_ld = 1'b0;
        w_widx_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    case (i_rx_data[7:0])
                        CMD_LOAD:  w_state_nxt = ST_LEN_LO;
                        CMD_START: w_start     = 1'b1;
                        CMD_HALT:  w_halt      = 1'b1;
                        default:   w_err       = 1'b1;
                    endcase
                end
            end
            ST_LEN_LO: begin
                if (w_event) begin
                    w_len_lo_ld = 1'b1;
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_event) begin
                    w_len_hi_ld = 1'b1;
                    if (w_len == 16'd0) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if ({1'b0, w_len} > MAX_WORDS) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_widx_clr  = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_word_ready) begin
                    w_we = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A byte arriving on the expiry cycle keeps the load alive.
        if ((r_state != ST_IDLE) && !w_event && (r_tmo == TMO_LAST)) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_done_q     <= 1'b0;
            r_count      <= 16'd0;
            r_widx       <= '0;
            r_tmo        <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_cpu_start  <= 1'b0;
            o_cpu_halt   <= 1'b0;
            o_load_done  <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_q    <= i_rx_done;
            o_imem_we   <= w_we;
            o_cpu_start <= w_start;
            o_cpu_halt  <= w_halt;
            o_load_done <= w_done;
            o_err       <= w_err;
            // Busy stays up through the cycle carrying the final write or error pulse.
            o_busy      <= (r_state != ST_IDLE) | (w_state_nxt != ST_IDLE);
            if (w_we) begin
                o_imem_addr  <= r_widx[NB_ADDR-1:0];
                o_imem_wdata <= w_word;
            end
            if (w_len_lo_ld) r_count[7:0] <= i_rx_data[7:0];
            if (w_len_hi_ld) r_count <= w_len;
            if (w_widx_clr) begin
                r_widx <= '0;
            end else if (w_we) begin
                r_widx <= r_widx + WIDX_ONE;
            end
            if ((r_state == ST_IDLE) || w_event || (w_state_nxt == ST_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_ONE;
            end
        end
    end

endmodule
